// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: datapath width, write-back
// select encodings, FSM state type and a small alignment helper.
package mem_pkg;

    localparam int XLEN = 32;

    // Write-back source select carried down from EX/MEM.
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_RSV = 2'd3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_t;

    // Word accesses only: any set bit in the low two address bits is a fault.
    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register. A bubble clears the write-back fields so the
// register file sees no write; bus_err is a one-cycle flag registered alongside.
module memwb_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bubble,
    input  logic         err_in,
    input  logic         we_reg_in,
    input  logic [4:0]   rdst_id_in,
    input  logic [W-1:0] data_in,
    output logic         wb_we_reg,
    output logic [4:0]   wb_rdst_id,
    output logic [W-1:0] wb_data,
    output logic         bus_err
);

    // Register the write-back fields, or a bubble, every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we_reg  <= 1'b0;
            wb_rdst_id <= 5'd0;
            wb_data    <= {W{1'b0}};
            bus_err    <= 1'b0;
        end else if (bubble) begin
            wb_we_reg  <= 1'b0;
            wb_rdst_id <= 5'd0;
            wb_data    <= {W{1'b0}};
            bus_err    <= err_in;
        end else begin
            wb_we_reg  <= we_reg_in;
            wb_rdst_id <= rdst_id_in;
            wb_data    <= data_in;
            bus_err    <= err_in;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-memory requests for loads and stores,
// stalls the pipe while a request is outstanding, aborts on timeout or
// misalignment, and selects the write-back value.
module mem_stage
    import mem_pkg::*;
#(
    parameter int XLEN    = mem_pkg::XLEN,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [XLEN-1:0] mem_pc,
    input  logic [XLEN-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_rs2,
    input  logic [4:0]      mem_rdst_id,
    input  logic            mem_we_reg,
    input  logic            mem_we_dmem,
    input  logic [1:0]      mem_wbsel,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall,
    output logic            wb_we_reg,
    output logic [4:0]      wb_rdst_id,
    output logic [XLEN-1:0] wb_data,
    output logic            bus_err
);

    localparam int             CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    mem_state_t     state_r;
    logic [CW-1:0]  cnt_r;
    logic [4:0]     lat_rdst_r;
    logic [1:0]     lat_wbsel_r;

    logic            is_store_s;
    logic            is_load_s;
    logic            is_mem_s;
    logic            misal_s;
    logic            timeout_s;
    logic            start_s;
    logic            stall_s;
    logic [XLEN-1:0] alu_mux_s;
    logic            wb_bubble_s;
    logic            wb_err_s;
    logic            wb_we_s;
    logic [4:0]      wb_rdst_s;
    logic [XLEN-1:0] wb_data_s;

    // Classify the incoming instruction and decide whether a request starts.
    always_comb begin
        is_store_s = mem_we_dmem;
        is_load_s  = !mem_we_dmem && (mem_wbsel == WB_MEM) && mem_we_reg;
        is_mem_s   = is_store_s || is_load_s;
        misal_s    = addr_misaligned(mem_rd[1:0]);
        timeout_s  = (cnt_r == CNT_LAST);
        if ((state_r == ST_IDLE) && !flush && is_mem_s && !misal_s) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
    end

    // Stall holds upstream while a request is being launched or awaits ack.
    always_comb begin
        stall_s = 1'b0;
        if (rst) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:   stall_s = start_s;
                ST_ACCESS: stall_s = !dmem_ack && !timeout_s;
                default:   stall_s = 1'b0;
            endcase
        end
    end

    assign stall = stall_s;

    // Write-back source select for instructions completing straight from IDLE.
    always_comb begin
        alu_mux_s = {XLEN{1'b0}};
        case (mem_wbsel)
            WB_ALU:  alu_mux_s = mem_rd;
            WB_MEM:  alu_mux_s = {XLEN{1'b0}};
            WB_PC4:  alu_mux_s = mem_pc + XLEN'(4);
            WB_RSV:  alu_mux_s = {XLEN{1'b0}};
            default: alu_mux_s = {XLEN{1'b0}};
        endcase
    end

    // Next write-back contents: real result, plain bubble, or error bubble.
    always_comb begin
        wb_bubble_s = 1'b1;
        wb_err_s    = 1'b0;
        wb_we_s     = 1'b0;
        wb_rdst_s   = 5'd0;
        wb_data_s   = {XLEN{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    wb_bubble_s = 1'b1;
                end else if (is_mem_s) begin
                    wb_bubble_s = 1'b1;
                    wb_err_s    = misal_s;
                end else begin
                    wb_bubble_s = 1'b0;
                    wb_we_s     = mem_we_reg;
                    wb_rdst_s   = mem_rdst_id;
                    wb_data_s   = alu_mux_s;
                end
            end
            ST_ACCESS: begin
                if (dmem_ack) begin
                    wb_bubble_s = 1'b0;
                    wb_rdst_s   = lat_rdst_r;
                    if (!dmem_we && (lat_wbsel_r == WB_MEM)) begin
                        wb_we_s   = 1'b1;
                        wb_data_s = dmem_rdata;
                    end else begin
                        wb_we_s   = 1'b0;
                        wb_data_s = {XLEN{1'b0}};
                    end
                end else if (timeout_s) begin
                    wb_bubble_s = 1'b1;
                    wb_err_s    = 1'b1;
                end else begin
                    wb_bubble_s = 1'b1;
                end
            end
            default: begin
                wb_bubble_s = 1'b1;
            end
        endcase
    end

    // Access FSM: latch the request on entry, hold it until ack or timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= {XLEN{1'b0}};
            dmem_wdata  <= {XLEN{1'b0}};
            lat_rdst_r  <= 5'd0;
            lat_wbsel_r <= WB_ALU;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r     <= ST_ACCESS;
                        cnt_r       <= {CW{1'b0}};
                        dmem_req    <= 1'b1;
                        dmem_we     <= is_store_s;
                        dmem_addr   <= mem_rd;
                        dmem_wdata  <= mem_rs2;
                        lat_rdst_r  <= mem_rdst_id;
                        lat_wbsel_r <= mem_wbsel;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack || timeout_s) begin
                        state_r  <= ST_IDLE;
                        cnt_r    <= {CW{1'b0}};
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                end
            endcase
        end
    end

    memwb_reg #(.W(XLEN)) u_memwb (
        .clk        (clk),
        .rst        (rst),
        .bubble     (wb_bubble_s),
        .err_in     (wb_err_s),
        .we_reg_in  (wb_we_s),
        .rdst_id_in (wb_rdst_s),
        .data_in    (wb_data_s),
        .wb_we_reg  (wb_we_reg),
        .wb_rdst_id (wb_rdst_id),
        .wb_data    (wb_data),
        .bus_err    (bus_err)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a vector table for single-cycle IDLE
// behaviour plus directed sequences for load, store, timeout and reset.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] mem_pc, mem_rd, mem_rs2;
    logic [4:0]  mem_rdst_id;
    logic        mem_we_reg, mem_we_dmem;
    logic [1:0]  mem_wbsel;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        wb_we_reg;
    logic [4:0]  wb_rdst_id;
    logic [31:0] wb_data;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_stage #(.XLEN(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .mem_pc(mem_pc), .mem_rd(mem_rd), .mem_rs2(mem_rs2),
        .mem_rdst_id(mem_rdst_id), .mem_we_reg(mem_we_reg),
        .mem_we_dmem(mem_we_dmem), .mem_wbsel(mem_wbsel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .wb_we_reg(wb_we_reg), .wb_rdst_id(wb_rdst_id),
        .wb_data(wb_data), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rd;
        logic [31:0] rs2;
        logic [4:0]  rdst;
        logic        we_reg;
        logic        we_dmem;
        logic [1:0]  wbsel;
        logic        flush;
        logic        exp_we;
        logic [4:0]  exp_rdst;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        chk_rdst;
        logic        chk_data;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] rd, input logic [31:0] rs2,
                         input logic [4:0] rdst, input logic we_reg, input logic we_dmem,
                         input logic [1:0] wbsel, input logic fl);
        mem_pc      = pc;
        mem_rd      = rd;
        mem_rs2     = rs2;
        mem_rdst_id = rdst;
        mem_we_reg  = we_reg;
        mem_we_dmem = we_dmem;
        mem_wbsel   = wbsel;
        flush       = fl;
    endtask

    task automatic nop();
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // pc, rd, rs2, rdst, we_reg, we_dmem, wbsel, flush, exp_we, exp_rdst, exp_data, exp_err, chk_rdst, chk_data
        vecs[0]  = '{32'h0,        32'h1234, 32'h0,        5'd5, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{32'h1000,     32'h9,    32'h0,        5'd1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd1, 32'h1004, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{32'hFFFFFFFC, 32'h0,    32'h0,        5'd2, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd2, 32'h0,    1'b0, 1'b1, 1'b1};
        vecs[3]  = '{32'h0,        32'h55,   32'h0,        5'd7, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 5'd7, 32'h0,    1'b0, 1'b1, 1'b1};
        vecs[4]  = '{32'h0,        32'hCAFE, 32'h0,        5'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 5'd0, 32'hCAFE, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{32'h0,        32'h77,   32'h0,        5'd9, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 5'd9, 32'h77,   1'b0, 1'b1, 1'b1};
        vecs[6]  = '{32'h0,        32'h102,  32'h0,        5'd3, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'h0,        32'h41,   32'hA5A5A5A5, 5'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0};
        vecs[8]  = '{32'h0,        32'h40,   32'hA5A5A5A5, 5'd0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0};
        vecs[9]  = '{32'h0,        32'h1234, 32'h0,        5'd5, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'h0,        32'h100,  32'h0,        5'd4, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 5'd4, 32'h0,    1'b0, 1'b1, 1'b0};

        // Reset with a load presented: no stall, everything zero.
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive(32'h0, 32'h100, 32'h0, 5'd3, 1'b1, 1'b0, 2'd1, 1'b0);
        tick();
        tick();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wb_we", {31'd0, wb_we_reg}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_err", {31'd0, bus_err}, 32'd0);
        nop();
        rst = 1'b0;
        tick();

        // Table: single-cycle IDLE cases; ack held high to show it is ignored.
        dmem_ack = 1'b1;
        dmem_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].pc, vecs[i].rd, vecs[i].rs2, vecs[i].rdst, vecs[i].we_reg,
                  vecs[i].we_dmem, vecs[i].wbsel, vecs[i].flush);
            #1;
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
            tick();
            chk($sformatf("v%0d_req", i), {31'd0, dmem_req}, 32'd0);
            chk($sformatf("v%0d_we", i), {31'd0, wb_we_reg}, {31'd0, vecs[i].exp_we});
            chk($sformatf("v%0d_err", i), {31'd0, bus_err}, {31'd0, vecs[i].exp_err});
            if (vecs[i].chk_rdst) chk($sformatf("v%0d_rdst", i), {27'd0, wb_rdst_id}, {27'd0, vecs[i].exp_rdst});
            if (vecs[i].chk_data) chk($sformatf("v%0d_data", i), wb_data, vecs[i].exp_data);
        end
        dmem_ack = 1'b0;
        nop();
        tick();
        chk("err_pulse_end", {31'd0, bus_err}, 32'd0);

        // Load at 0x100, ack three cycles after the request rises.
        drive(32'h0, 32'h100, 32'h0, 5'd10, 1'b1, 1'b0, 2'd1, 1'b0);
        #1;
        chk("ld_stall_c0", {31'd0, stall}, 32'd1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("ld_req_c%0d", c), {31'd0, dmem_req}, 32'd1);
            chk($sformatf("ld_addr_c%0d", c), dmem_addr, 32'h100);
            chk($sformatf("ld_dwe_c%0d", c), {31'd0, dmem_we}, 32'd0);
            chk($sformatf("ld_stall_c%0d", c), {31'd0, stall}, 32'd1);
            if (c == 2) flush = 1'b1;
            if (c == 3) flush = 1'b0;
        end
        tick();
        chk("ld_req_c4", {31'd0, dmem_req}, 32'd1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_stall_ack", {31'd0, stall}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        nop();
        chk("ld_wb_data", wb_data, 32'hDEADBEEF);
        chk("ld_wb_we", {31'd0, wb_we_reg}, 32'd1);
        chk("ld_wb_rdst", {27'd0, wb_rdst_id}, 32'd10);
        chk("ld_req_drop", {31'd0, dmem_req}, 32'd0);

        // Load with immediate ack: result two cycles after presentation.
        drive(32'h0, 32'h104, 32'h0, 5'd11, 1'b1, 1'b0, 2'd1, 1'b0);
        tick();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h13579BDF;
        tick();
        dmem_ack = 1'b0;
        nop();
        chk("ld2_wb_data", wb_data, 32'h13579BDF);
        chk("ld2_wb_we", {31'd0, wb_we_reg}, 32'd1);

        // Store at 0x40 with immediate ack.
        drive(32'h0, 32'h40, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b1, 2'd0, 1'b0);
        #1;
        chk("st_stall_c0", {31'd0, stall}, 32'd1);
        tick();
        chk("st_dwe_c1", {31'd0, dmem_we}, 32'd1);
        chk("st_wdata_c1", dmem_wdata, 32'hA5A5A5A5);
        chk("st_addr_c1", dmem_addr, 32'h40);
        dmem_ack = 1'b1;
        #1;
        chk("st_stall_ack", {31'd0, stall}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        nop();
        chk("st_dwe_c2", {31'd0, dmem_we}, 32'd0);
        chk("st_req_c2", {31'd0, dmem_req}, 32'd0);
        chk("st_wb_we", {31'd0, wb_we_reg}, 32'd0);

        // Timeout: load at 0x200, no ack ever.
        drive(32'h0, 32'h200, 32'h0, 5'd12, 1'b1, 1'b0, 2'd1, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk($sformatf("to_req_c%0d", c), {31'd0, dmem_req}, 32'd1);
            chk($sformatf("to_stall_c%0d", c), {31'd0, stall}, (c < 16) ? 32'd1 : 32'd0);
            chk($sformatf("to_err_c%0d", c), {31'd0, bus_err}, 32'd0);
        end
        tick();
        nop();
        chk("to_err_pulse", {31'd0, bus_err}, 32'd1);
        chk("to_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("to_wb_we", {31'd0, wb_we_reg}, 32'd0);
        tick();
        chk("to_err_end", {31'd0, bus_err}, 32'd0);

        // Reset in the middle of an access, then a late ack.
        drive(32'h0, 32'h300, 32'h0, 5'd13, 1'b1, 1'b0, 2'd1, 1'b0);
        tick();
        chk("rr_req", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rr_stall_rst", {31'd0, stall}, 32'd0);
        tick();
        rst = 1'b0;
        nop();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h11111111;
        #1;
        chk("rr_req0", {31'd0, dmem_req}, 32'd0);
        chk("rr_addr0", dmem_addr, 32'd0);
        chk("rr_stall0", {31'd0, stall}, 32'd0);
        chk("rr_wb_we0", {31'd0, wb_we_reg}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        chk("rr_late_we", {31'd0, wb_we_reg}, 32'd0);
        chk("rr_late_data", wb_data, 32'd0);
        chk("rr_late_req", {31'd0, dmem_req}, 32'd0);
        drive(32'h0, 32'h2468, 32'h0, 5'd6, 1'b1, 1'b0, 2'd0, 1'b0);
        tick();
        nop();
        chk("rr_after_data", wb_data, 32'h2468);
        chk("rr_after_we", {31'd0, wb_we_reg}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
